// File: rtl/packet_sorter.sv
// packet_sorter: routes BCH-decoded HDMI data-island packets to an audio FIFO,
// ACR registers and InfoFrame fields, with checksum and collision handling.
module packet_sorter #(
    parameter int AUDIO_FIFO_DEPTH = 8
) (
    input  logic             clk_pixel,
    input  logic             reset_n,
    input  logic             packet_valid,
    input  logic [23:0]      header,
    input  logic [3:0][55:0] sub,
    input  logic             header_error,
    input  logic [3:0]       sub_error,
    output logic [47:0]      audio_sample_word,
    output logic             audio_valid,
    input  logic             audio_ready,
    output logic             audio_block_start,
    output logic [19:0]      cts,
    output logic [19:0]      n,
    output logic             acr_update,
    output logic [6:0]       video_id_code,
    output logic [2:0]       audio_channel_count,
    output logic             packet_dropped,
    output logic             checksum_error,
    output logic             audio_overflow
);
    localparam int AW = $clog2(AUDIO_FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, AUDIO, INFO, COMMIT} state_t;

    state_t           state_q;
    logic [7:0]       type_q, sum_q, sub_sum;
    logic [3:0]       present_q, bflag_q, serr_q;
    logic [3:0][55:0] sub_q;
    logic [1:0]       k_q;
    logic [48:0]      mem_q [AUDIO_FIFO_DEPTH];
    logic [48:0]      last_q, head;
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic [19:0]      cts_q, n_q;
    logic [6:0]       vic_q;
    logic [2:0]       cc_q;
    logic             acr_q, drop_q, cerr_q, ovf_q;
    logic             full, push, pop, wr_en;

    assign full  = cnt_q == (AW+1)'(AUDIO_FIFO_DEPTH);
    assign audio_valid = cnt_q != '0;
    assign pop   = audio_valid && audio_ready;
    assign push  = state_q == AUDIO && present_q[k_q] && !serr_q[k_q];
    assign wr_en = push && (!full || pop);
    // Once drained, the output keeps showing the most recently popped sample.
    assign head  = audio_valid ? mem_q[rd_q] : last_q;
    assign audio_sample_word   = head[48:1];
    assign audio_block_start   = head[0];
    assign cts                 = cts_q;
    assign n                   = n_q;
    assign acr_update          = acr_q;
    assign video_id_code       = vic_q;
    assign audio_channel_count = cc_q;
    assign packet_dropped      = drop_q;
    assign checksum_error      = cerr_q;
    assign audio_overflow      = ovf_q;

    always_comb begin
        sub_sum = sum_q;
        for (int i = 0; i < 7; i++) sub_sum = sub_sum + sub_q[k_q][8*i +: 8];
    end

    always_ff @(posedge clk_pixel)
        if (wr_en) mem_q[wr_q] <= {sub_q[k_q][47:0], bflag_q[k_q]};

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            type_q    <= '0;
            sum_q     <= '0;
            present_q <= '0;
            bflag_q   <= '0;
            serr_q    <= '0;
            sub_q     <= '0;
            k_q       <= '0;
            last_q    <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            cts_q     <= '0;
            n_q       <= '0;
            vic_q     <= '0;
            cc_q      <= '0;
            acr_q     <= 1'b0;
            drop_q    <= 1'b0;
            cerr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            acr_q  <= 1'b0;
            cerr_q <= 1'b0;
            drop_q <= packet_valid && (state_q != IDLE || header_error);
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (pop) begin
                rd_q   <= rd_q + 1'b1;
                last_q <= mem_q[rd_q];
            end
            cnt_q <= cnt_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
            if (push && !wr_en) ovf_q <= 1'b1;
            case (state_q)
                IDLE: if (packet_valid && !header_error) begin
                    type_q    <= header[7:0];
                    present_q <= header[11:8];
                    bflag_q   <= header[23:20];
                    serr_q    <= sub_error;
                    sub_q     <= sub;
                    k_q       <= '0;
                    sum_q     <= header[7:0] + header[15:8] + header[23:16];
                    if (header[7:0] == 8'h01) begin
                        if (sub_error[0]) drop_q <= 1'b1;
                        else begin
                            cts_q <= {sub[0][11:8], sub[0][23:16], sub[0][31:24]};
                            n_q   <= {sub[0][35:32], sub[0][47:40], sub[0][55:48]};
                            acr_q <= 1'b1;
                        end
                    end
                    state_q <= header[7:0] == 8'h02 ? AUDIO :
                               header[7:0] inside {8'h82, 8'h83, 8'h84} ? INFO : IDLE;
                end
                AUDIO: begin
                    k_q <= k_q + 2'd1;
                    if (k_q == 2'd3) state_q <= IDLE;
                end
                INFO: begin
                    sum_q <= sub_sum;
                    k_q   <= k_q + 2'd1;
                    if (k_q == 2'd3) state_q <= COMMIT;
                end
                COMMIT: begin
                    state_q <= IDLE;
                    if (sum_q == 8'd0 && serr_q == 4'd0) begin
                        if (type_q == 8'h82) vic_q <= sub_q[0][38:32];
                        if (type_q == 8'h84) cc_q <= sub_q[0][10:8];
                    end else cerr_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_packet_sorter.sv
// tb_packet_sorter: directed self-checking bench for packet_sorter with
// hand-computed expectations.
module tb_packet_sorter;
    logic             clk = 1'b0;
    logic             reset_n;
    logic             packet_valid;
    logic [23:0]      header;
    logic [3:0][55:0] sub;
    logic             header_error;
    logic [3:0]       sub_error;
    logic [47:0]      audio_sample_word;
    logic             audio_valid, audio_ready, audio_block_start;
    logic [19:0]      cts, n;
    logic             acr_update;
    logic [6:0]       video_id_code;
    logic [2:0]       audio_channel_count;
    logic             packet_dropped, checksum_error, audio_overflow;
    int               tests = 0;
    int               fails = 0;

    packet_sorter #(.AUDIO_FIFO_DEPTH(8)) dut (
        .clk_pixel(clk), .reset_n(reset_n), .packet_valid(packet_valid),
        .header(header), .sub(sub), .header_error(header_error), .sub_error(sub_error),
        .audio_sample_word(audio_sample_word), .audio_valid(audio_valid),
        .audio_ready(audio_ready), .audio_block_start(audio_block_start),
        .cts(cts), .n(n), .acr_update(acr_update), .video_id_code(video_id_code),
        .audio_channel_count(audio_channel_count), .packet_dropped(packet_dropped),
        .checksum_error(checksum_error), .audio_overflow(audio_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick(input int k = 1);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [23:0] h, input logic [3:0][55:0] s,
                        input logic herr, input logic [3:0] serr);
        packet_valid = 1'b1;
        header = h;
        sub = s;
        header_error = herr;
        sub_error = serr;
        tick();
        packet_valid = 1'b0;
        header_error = 1'b0;
        sub_error = '0;
    endtask

    function automatic logic [55:0] smp(input logic [23:0] r, input logic [23:0] l);
        return {8'h00, r, l};
    endfunction

    logic [3:0][55:0] s;

    initial begin
        reset_n = 1'b0;
        packet_valid = 1'b0;
        header = '0;
        sub = '0;
        header_error = 1'b0;
        sub_error = '0;
        audio_ready = 1'b0;
        tick(3);
        chk("rst_valid", audio_valid, 0);
        chk("rst_word", audio_sample_word, 0);
        chk("rst_bstart", audio_block_start, 0);
        chk("rst_cts", cts, 0);
        chk("rst_n", n, 0);
        chk("rst_vic", video_id_code, 0);
        chk("rst_cc", audio_channel_count, 0);
        chk("rst_pulses", {acr_update, packet_dropped, checksum_error, audio_overflow}, 0);
        reset_n = 1'b1;
        tick(2);

        // ACR with good subpacket 0
        s = '0;
        s[0] = 56'h00_18_00_A0_86_01_00;
        send(24'h000001, s, 1'b0, 4'h0);
        chk("acr_pulse", acr_update, 1);
        chk("acr_cts", cts, 20'h186A0);
        chk("acr_n", n, 20'h01800);
        tick();
        chk("acr_pulse_end", acr_update, 0);
        chk("acr_cts_hold", cts, 20'h186A0);

        // ACR with sub_error[0]: dropped, no update
        s[0] = 56'h00_22_00_33_44_05_00;
        send(24'h000001, s, 1'b0, 4'h1);
        chk("acr_serr_drop", packet_dropped, 1);
        chk("acr_serr_noupd", {acr_update, cts}, {1'b0, 20'h186A0});
        // Header error
        send(24'h000001, s, 1'b1, 4'h0);
        chk("herr_drop", packet_dropped, 1);
        chk("herr_noupd", {acr_update, n}, {1'b0, 20'h01800});
        // Unknown type ignored silently
        send(24'h000005, s, 1'b0, 4'h0);
        chk("unk_silent", {packet_dropped, acr_update}, 0);
        tick();

        // Audio: slots 0 and 2 present
        s = '0;
        s[0] = smp(24'h123456, 24'hABCDEF);
        s[2] = smp(24'h000002, 24'h000001);
        send(24'h100502, s, 1'b0, 4'h0);
        tick(4);
        chk("aud_valid", audio_valid, 1);
        chk("aud_w0", audio_sample_word, 48'h123456ABCDEF);
        chk("aud_b0", audio_block_start, 1);
        audio_ready = 1'b1;
        tick();
        chk("aud_w1", {audio_valid, audio_sample_word}, {1'b1, 48'h000002000001});
        chk("aud_b1", audio_block_start, 0);
        tick();
        chk("aud_empty", audio_valid, 0);
        tick(2);
        chk("aud_hold", audio_sample_word, 48'h000002000001);
        audio_ready = 1'b0;

        // Collision during AUDIO
        for (int k = 0; k < 4; k++) s[k] = smp(24'(16 + k), 24'(32 + k));
        send(24'h000F02, s, 1'b0, 4'h0);
        s[0] = 56'h00_11_00_22_33_02_00;
        send(24'h000001, s, 1'b0, 4'h0);
        chk("col_drop", packet_dropped, 1);
        chk("col_noacr", {acr_update, cts}, {1'b0, 20'h186A0});
        tick(3);
        audio_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("col_pop%0d", k), {audio_valid, audio_sample_word},
                {1'b1, 24'(16 + k), 24'(32 + k)});
            tick();
        end
        chk("col_empty", audio_valid, 0);
        audio_ready = 1'b0;

        // Overflow: three full packets into depth 8
        for (int p = 0; p < 3; p++) begin
            if (p == 2) chk("ovf_full_noflag", {audio_valid, audio_overflow}, 2'b10);
            for (int k = 0; k < 4; k++) s[k] = smp(24'(256 + p * 4 + k), 24'(p * 4 + k));
            send(24'h000F02, s, 1'b0, 4'h0);
            tick(4);
        end
        chk("ovf_flag", audio_overflow, 1);
        audio_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf_pop%0d", i), {audio_valid, audio_sample_word},
                {1'b1, 24'(256 + i), 24'(i)});
            tick();
        end
        chk("ovf_empty", audio_valid, 0);
        chk("ovf_sticky", audio_overflow, 1);
        audio_ready = 1'b0;

        // AVI InfoFrame, good checksum
        s = '0;
        s[0] = 56'h00_00_10_00_00_00_5F;
        send(24'h0D0282, s, 1'b0, 4'h0);
        tick(5);
        chk("avi_vic", video_id_code, 16);
        chk("avi_nocerr", checksum_error, 0);
        // PB0 incremented
        s[0] = 56'h00_00_10_00_00_00_60;
        send(24'h0D0282, s, 1'b0, 4'h0);
        tick(5);
        chk("avi_cerr", checksum_error, 1);
        tick();
        chk("avi_cerr_end", checksum_error, 0);
        // Bad checksum with a different VIC must not latch
        s[0] = 56'h00_00_11_00_00_00_5F;
        send(24'h0D0282, s, 1'b0, 4'h0);
        tick(5);
        chk("avi_bad_vic", {checksum_error, video_id_code}, {1'b1, 7'd16});
        // Audio InfoFrame
        s[0] = 56'h00_00_00_00_00_03_6E;
        send(24'h0A0184, s, 1'b0, 4'h0);
        tick(5);
        chk("aif_cc", {checksum_error, audio_channel_count}, {1'b0, 3'd3});
        // Good checksum but sub_error on subpacket 2
        s[0] = 56'h00_00_00_00_00_05_6C;
        send(24'h0A0184, s, 1'b0, 4'b0100);
        tick(5);
        chk("aif_serr", {checksum_error, audio_channel_count}, {1'b1, 3'd3});

        // Reset in the middle of AUDIO
        for (int k = 0; k < 4; k++) s[k] = smp(24'(64 + k), 24'(80 + k));
        send(24'h000F02, s, 1'b0, 4'h0);
        tick(2);
        chk("mid_partial", audio_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_async_empty", audio_valid, 0);
        tick(2);
        reset_n = 1'b1;
        tick(4);
        chk("mid_after_empty", {audio_valid, audio_sample_word}, 0);
        chk("mid_after_ovf", audio_overflow, 0);
        s = '0;
        s[0] = 56'h00_18_00_A0_86_01_00;
        send(24'h000001, s, 1'b0, 4'h0);
        chk("mid_accept", {acr_update, cts}, {1'b1, 20'h186A0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/packet_sorter.md
PACKET_SORTER -- requirements
Module: packet_sorter

Interface
REQ-001 SHALL have parameter AUDIO_FIFO_DEPTH, default 8, stereo-sample entries (power of two, 4..64).
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk_pixel  input  1  pixel clock; all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 packet_valid  input  1  one-cycle strobe: header/sub hold a BCH-decoded data-island packet.
REQ-006 header  input  24  {HB2, HB1, HB0}; HB0 = packet type.
REQ-007 sub  input  4x56  subpackets 0..3; byte n = bits [8n+7:8n].
REQ-008 header_error / sub_error  input  1 / 4  uncorrectable BCH error on header / subpacket k.
REQ-009 audio_sample_word  output  2x24  {right, left} at FIFO head.
REQ-010 audio_valid / audio_ready  output / input  1 / 1  FIFO-pop handshake.
REQ-011 audio_block_start  output  1  IEC 60958 B flag of the head sample.
REQ-012 cts, n  output  20 each  last accepted ACR values.
REQ-013 acr_update  output  1  one-cycle pulse when cts/n load.
REQ-014 video_id_code  output  7  VIC from last valid AVI InfoFrame.
REQ-015 audio_channel_count  output  3  CC field from last valid Audio InfoFrame.
REQ-016 packet_dropped, checksum_error  output  1 each  one-cycle pulses.
REQ-017 audio_overflow  output  1  sticky; cleared only by reset.

Function
REQ-018 FSM states IDLE, AUDIO, INFO, COMMIT; only IDLE accepts packet_valid.
REQ-019 packet_valid outside IDLE: packet ignored, packet_dropped pulses next cycle.
REQ-020 IDLE with packet_valid and header_error=1: packet ignored, packet_dropped pulses, FSM stays IDLE.
REQ-021 Accepted packet: header and sub registered into a capture buffer in the accept cycle.
REQ-022 Type 0x00 and types other than 0x01, 0x02, 0x82, 0x83, 0x84: ignored silently, stay IDLE.
REQ-023 Type 0x01 (ACR), sub_error[0]=0: next cycle cts = {SB1[3:0], SB2, SB3}, n = {SB4[3:0], SB5, SB6} of sub[0], acr_update=1 for one cycle; stay IDLE.
REQ-024 Type 0x01 with sub_error[0]=1: no update, packet_dropped pulses.
REQ-025 Type 0x02: go to AUDIO; iterate k=0..3 one per cycle (exactly 4 cycles), then IDLE.
REQ-026 AUDIO push at k iff HB1[k]=1 and sub_error[k]=0; entry = {sub[k][47:24], sub[k][23:0], HB2[4+k]}.
REQ-027 Push when FIFO full: sample discarded, audio_overflow set.
REQ-028 Types 0x82/0x83/0x84: go to INFO; 4 cycles add the 7 bytes of sub[k] to an 8-bit sum seeded with HB0+HB1+HB2 (mod 256); then COMMIT.
REQ-029 COMMIT (1 cycle): sum==0 and sub_error==0 -> latch fields; otherwise checksum_error pulses, nothing latched; return to IDLE.
REQ-030 Latch fields: 0x82 -> video_id_code = sub[0][38:32] (PB4[6:0]); 0x84 -> audio_channel_count = sub[0][10:8] (PB1[2:0]); 0x83 -> checksum check only.
REQ-031 FIFO: first-word fall-through; audio_valid = not empty; pop on audio_valid & audio_ready; push and pop in the same cycle when full both succeed, no overflow.
REQ-032 Occupancy counter width clog2(AUDIO_FIFO_DEPTH)+1; read/write pointers wrap modulo depth.
REQ-033 audio_ready with FIFO empty: no effect; audio_sample_word holds last value.

Reset
REQ-034 reset_n low asynchronously forces IDLE, FIFO empty, audio_valid=0, audio_sample_word=0, audio_block_start=0, cts=0, n=0, video_id_code=0, audio_channel_count=0, all pulses 0, audio_overflow=0.
REQ-035 Reset mid-AUDIO/INFO aborts the packet; no partial pushes or latches survive; first packet_valid after release is accepted in IDLE.

Verification
REQ-036 ACR: type 0x01, sub[0] bytes 0..6 = 00,01,86,A0,00,18,00 -> cts=0x186A0, n=0x01800, acr_update one pulse.
REQ-037 Audio: HB1=0x05, HB2=0x10, sub[0]={R=0x123456,L=0xABCDEF}, sub[2]={R=0x000002,L=0x000001}, audio_ready=1 -> exactly two pops in order, first with audio_block_start=1, second with 0.
REQ-038 Overflow: depth 8, audio_ready=0, three packets HB1=0x0F -> 8 entries held, audio_overflow=1, first 8 samples pop in order.
REQ-039 AVI: type 0x82, HB1=0x02, HB2=0x0D, PB4=0x10, PB0 = correct checksum -> video_id_code=16; same packet with PB0 incremented -> checksum_error pulse, video_id_code unchanged.
REQ-040 Collision: second packet_valid during AUDIO -> packet_dropped pulse, first packet's samples fully pushed.
REQ-041 Reset: reset_n asserted in cycle 2 of AUDIO with HB1=0x0F -> FIFO empty and audio_valid=0 after release.
